// File: rtl/mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// mac_sequencer_if
//   Bundles every non-clock/reset signal of mac_sequencer. Signal names keep
//   the sequencer's point of view (_i = into the sequencer, _o = out of it).
//
//   Window request : start_i, start_ready_o, fmap_base_i, kern_base_i, bias_i
//   Memory         : fmap_addr_o, kern_addr_o, mem_rd_en_o,
//                    fmap_rdata_i, kern_rdata_i (valid one cycle after read)
//   MAC            : mac_valid_o, mac_fin_data_o, mac_kernel_data_o,
//                    mac_kernel_bias_o, mac_ready_o, mac_valid_i, mac_data_i
//   Result         : res_valid_o, res_data_o, res_err_o, res_ready_i
//
//   Modports: master = sequencer side, slave = surrounding system side.
// ---------------------------------------------------------------------------
interface mac_sequencer_if #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int ADDR_WIDTH            = 10
);
    // Window request
    logic                             start_i;
    logic                             start_ready_o;
    logic [ADDR_WIDTH-1:0]            fmap_base_i;
    logic [ADDR_WIDTH-1:0]            kern_base_i;
    logic [OUTPUT_BIT_RESOLUTION-1:0] bias_i;

    // Memory
    logic [ADDR_WIDTH-1:0]            fmap_addr_o;
    logic [ADDR_WIDTH-1:0]            kern_addr_o;
    logic                             mem_rd_en_o;
    logic [INPUT_BIT_RESOLUTION-1:0]  fmap_rdata_i;
    logic [INPUT_BIT_RESOLUTION-1:0]  kern_rdata_i;

    // MAC
    logic                             mac_valid_o;
    logic [INPUT_BIT_RESOLUTION-1:0]  mac_fin_data_o;
    logic [INPUT_BIT_RESOLUTION-1:0]  mac_kernel_data_o;
    logic [OUTPUT_BIT_RESOLUTION-1:0] mac_kernel_bias_o;
    logic                             mac_ready_o;
    logic                             mac_valid_i;
    logic [OUTPUT_BIT_RESOLUTION-1:0] mac_data_i;

    // Result
    logic                             res_valid_o;
    logic [OUTPUT_BIT_RESOLUTION-1:0] res_data_o;
    logic                             res_err_o;
    logic                             res_ready_i;

    modport master (
        input  start_i, fmap_base_i, kern_base_i, bias_i,
        input  fmap_rdata_i, kern_rdata_i,
        input  mac_valid_i, mac_data_i,
        input  res_ready_i,
        output start_ready_o,
        output fmap_addr_o, kern_addr_o, mem_rd_en_o,
        output mac_valid_o, mac_fin_data_o, mac_kernel_data_o,
        output mac_kernel_bias_o, mac_ready_o,
        output res_valid_o, res_data_o, res_err_o
    );

    modport slave (
        output start_i, fmap_base_i, kern_base_i, bias_i,
        output fmap_rdata_i, kern_rdata_i,
        output mac_valid_i, mac_data_i,
        output res_ready_i,
        input  start_ready_o,
        input  fmap_addr_o, kern_addr_o, mem_rd_en_o,
        input  mac_valid_o, mac_fin_data_o, mac_kernel_data_o,
        input  mac_kernel_bias_o, mac_ready_o,
        input  res_valid_o, res_data_o, res_err_o
    );
endinterface

// File: rtl/mac_sequencer.sv
// ---------------------------------------------------------------------------
// mac_sequencer
//   Streams one convolution window (KERNEL_TAPS feature/kernel operand pairs)
//   from two synchronous-read memories into an external MAC, waits for the
//   MAC result and presents it on a valid/ready result port.
//
//   Sequence: IDLE -> PRIME (issue first read, zero priming beat)
//             -> STREAM (KERNEL_TAPS operand beats, reads run one ahead)
//             -> DRAIN (wait for MAC result) -> HOLD (result handshake).
//
//   Ports:
//     clk_i  : clock, all state updates on the rising edge
//     rst_i  : synchronous active-high reset
//     bus    : mac_sequencer_if.master (window request, memory, MAC, result)
//
//   Optional feature: define MAC_SEQ_TIMEOUT_EN to add a DRAIN watchdog.
//   After TIMEOUT_CYCLES DRAIN cycles without mac_valid_i the sequencer
//   moves to HOLD with an all-ones result and res_err_o=1. Without the macro
//   DRAIN waits forever and res_err_o is tied to 0.
// ---------------------------------------------------------------------------
module mac_sequencer #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int KERNEL_TAPS           = 9,
    parameter int ADDR_WIDTH            = 10,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mac_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } state_e;

    // Beat index of the final STREAM cycle (taps are limited to 1..255).
    localparam logic [7:0] LAST_BEAT = 8'(KERNEL_TAPS - 1);

    state_e                           state_q, state_d;
    logic [7:0]                       beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]            fmap_base_q, fmap_base_d;
    logic [ADDR_WIDTH-1:0]            kern_base_q, kern_base_d;
    logic [OUTPUT_BIT_RESOLUTION-1:0] bias_q, bias_d;
    logic [OUTPUT_BIT_RESOLUTION-1:0] res_data_q, res_data_d;
    logic [ADDR_WIDTH-1:0]            rd_offset;

`ifdef MAC_SEQ_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            res_err_q, res_err_d;
`endif

    // Reads run one address ahead of the beat being consumed; the add wraps
    // naturally at the address width.
    assign rd_offset = ADDR_WIDTH'(beat_q) + ADDR_WIDTH'(1);

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            fmap_base_q <= '0;
            kern_base_q <= '0;
            bias_q      <= '0;
            res_data_q  <= '0;
`ifdef MAC_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
            res_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            fmap_base_q <= fmap_base_d;
            kern_base_q <= kern_base_d;
            bias_q      <= bias_d;
            res_data_q  <= res_data_d;
`ifdef MAC_SEQ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            res_err_q   <= res_err_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        beat_d      = beat_q;
        fmap_base_d = fmap_base_q;
        kern_base_d = kern_base_q;
        bias_d      = bias_q;
        res_data_d  = res_data_q;
`ifdef MAC_SEQ_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        res_err_d   = res_err_q;
`endif

        bus.start_ready_o     = 1'b0;
        bus.mem_rd_en_o       = 1'b0;
        bus.fmap_addr_o       = '0;
        bus.kern_addr_o       = '0;
        bus.mac_valid_o       = 1'b0;
        bus.mac_fin_data_o    = '0;
        bus.mac_kernel_data_o = '0;
        bus.mac_kernel_bias_o = '0;
        bus.mac_ready_o       = 1'b0;
        bus.res_valid_o       = 1'b0;

        case (state_q)
            IDLE: begin
                bus.start_ready_o = 1'b1;
                if (bus.start_i) begin
                    fmap_base_d = bus.fmap_base_i;
                    kern_base_d = bus.kern_base_i;
                    bias_d      = bus.bias_i;
                    state_d     = PRIME;
                end
            end

            PRIME: begin
                // Priming beat: zero operands let the MAC load the bias while
                // the first read is in flight.
                bus.mem_rd_en_o       = 1'b1;
                bus.fmap_addr_o       = fmap_base_q;
                bus.kern_addr_o       = kern_base_q;
                bus.mac_valid_o       = 1'b1;
                bus.mac_kernel_bias_o = bias_q;
                beat_d                = '0;
                state_d               = STREAM;
            end

            STREAM: begin
                bus.mac_valid_o       = 1'b1;
                bus.mac_fin_data_o    = bus.fmap_rdata_i;
                bus.mac_kernel_data_o = bus.kern_rdata_i;
                bus.mac_kernel_bias_o = bias_q;
                if (beat_q != LAST_BEAT) begin
                    bus.mem_rd_en_o = 1'b1;
                    bus.fmap_addr_o = fmap_base_q + rd_offset;
                    bus.kern_addr_o = kern_base_q + rd_offset;
                    beat_d          = beat_q + 8'd1;
                end else begin
`ifdef MAC_SEQ_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                    state_d  = DRAIN;
                end
            end

            DRAIN: begin
                bus.mac_ready_o       = 1'b1;
                bus.mac_kernel_bias_o = bias_q;
                if (bus.mac_valid_i) begin
                    res_data_d = bus.mac_data_i;
`ifdef MAC_SEQ_TIMEOUT_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = HOLD;
                end
`ifdef MAC_SEQ_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    res_data_d = '1;
                    res_err_d  = 1'b1;
                    state_d    = HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end

            HOLD: begin
                bus.res_valid_o = 1'b1;
                if (bus.res_ready_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.res_data_o = res_data_q;

`ifdef MAC_SEQ_TIMEOUT_EN
    assign bus.res_err_o = res_err_q;
`else
    assign bus.res_err_o = 1'b0;
`endif

endmodule
